// File: rtl/pipelined_mux_tree.sv
// Radix-R N:1 mux tree with one register stage per tree level and a
// valid/ready handshake whose stall chain lets bubbles collapse.
module pipelined_mux_tree #(
  parameter int M = 8,
  parameter int N = 16,
  parameter int R = 4,
  localparam int SW = $clog2(N),
  localparam int B = (R == 4) ? 2 : 1,
  localparam int L = (SW + B - 1) / B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*M-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   out_data,
  output logic           out_sel_err,
  output logic           out_valid,
  input  logic           out_ready
);
  localparam int PW = L * B;
  localparam int LV = R ** L;

  logic [LV*M-1:0] leaf;
  logic [PW-1:0]   sel_p;
  logic            err_in;

  assign leaf   = (LV*M)'(in_data);
  assign sel_p  = PW'(in_sel);
  assign err_in = 32'(in_sel) >= 32'(N);

  for (genvar j = 0; j < L; j++) begin : st
    localparam int CNT = R ** (L - 1 - j);
    localparam int UW  = (L - j) * B;

    logic [CNT*R*M-1:0] up_d;
    logic [UW-1:0]      up_s;
    logic               up_v;
    logic               up_e;
    logic               dn;
    logic               adv;
    logic               v;
    logic               e;
    logic [CNT*M-1:0]   nxt;
    logic [CNT*M-1:0]   d;

    if (j == 0) begin : g_up0
      assign up_d = leaf;
      assign up_s = sel_p;
      assign up_v = in_valid;
      assign up_e = err_in;
    end else begin : g_upn
      assign up_d = st[j-1].d;
      assign up_s = st[j-1].g_s.s;
      assign up_v = st[j-1].v;
      assign up_e = st[j-1].e;
    end

    if (j == L - 1) begin : g_dnl
      assign dn = out_ready;
    end else begin : g_dnn
      assign dn = st[j+1].adv;
    end

    assign adv = !v || dn;

    always_comb begin
      nxt = '0;
      for (int g = 0; g < CNT; g++)
        nxt[g*M +: M] = up_d[(g*R + int'(up_s[B-1:0]))*M +: M];
    end

    // Payload only moves with a real beat, so bubbles never disturb it.
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        e <= 1'b0;
        d <= '0;
      end else if (adv) begin
        v <= up_v;
        if (up_v) begin
          e <= up_e;
          d <= up_e ? '0 : nxt;
        end
      end
    end

    if (j < L - 1) begin : g_s
      logic [UW-B-1:0] s;
      always_ff @(posedge clk) begin
        if (rst)
          s <= '0;
        else if (adv && up_v)
          s <= up_s[UW-1:B];
      end
    end
  end

  assign in_ready    = st[0].adv;
  assign out_valid   = st[L-1].v;
  assign out_data    = st[L-1].d;
  assign out_sel_err = st[L-1].e;

endmodule

// File: doc/pipelined_mux_tree.md
Name: pipelined_mux_tree

Overview:
- Parametrised N-to-1 multiplexer built as a radix-R tree with one register stage per tree level.
- Carries a valid/ready handshake with per-stage bubble collapsing.
- Generalises the fixed 2/4/8/16-to-1 combinational mux family to arbitrary N, R and M. Suited to wide operand-select paths where a flat mux breaks timing.
- Output selection order is fixed: sel=k always returns in[k*M +: M].

Parameters:
- M, 8, data width per input in bits (>=1).
- N, 16, number of inputs (>=2, need not be a power of R).
- R, 4, tree radix (2 or 4).
- SW, $clog2(N), select width (derived, localparam).
- L, ceil(log_R(N)), number of tree levels = pipeline depth (derived, localparam).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*M  packed inputs; input k occupies in_data[k*M +: M].
- in_sel  input  SW  select index.
- in_valid  input  1  upstream valid.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- out_data  output  M  selected data.
- out_sel_err  output  1  set when the beat's in_sel >= N (out_data is 0 for that beat).
- out_valid  output  1  downstream valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Tree structure:
  - N is padded to R^L leaves with zero data.
  - Level j (j=0..L-1) uses select digit in_sel bits [j*log2(R) +: log2(R)], LSB digit first.
  - Within a group, child c selects leaf group index c. No reversed concatenation anywhere.
- Stage j holds:
  - valid bit v[j];
  - the R^(L-1-j) partial results, M bits each;
  - the remaining upper select digits;
  - the err bit.
  - Only stage state needed downstream is registered. Stage L-1 drives out_data, out_valid and out_sel_err directly from registers.
- Err: err = (in_sel >= N), computed at capture into stage 0. Forces the final data to 0.
- Advance rule (per stage, combinational):
  - adv[L-1] = !v[L-1] || out_ready.
  - adv[j] = !v[j] || adv[j+1], for j < L-1.
  - in_ready = adv[0].
  - Bubbles collapse. in_ready depends on out_ready combinationally through the chain.
- Register update on the clk edge when adv[j]:
  - stage j loads from stage j-1 (stage 0 loads from the inputs).
  - v[j] <= upstream valid (in_valid for j=0).
  - When !adv[j], stage j holds all contents.
- Latency and throughput:
  - Latency is exactly L cycles from an accepted input to out_valid when there is no back-pressure.
  - Throughput is 1 beat/cycle when out_ready stays high.
- Ordering: beats are never reordered, dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_data and out_sel_err hold stable.
- Reset (synchronous, active-high):
  - rst=1 clears all v[j] to 0 on the next edge.
  - out_valid=0, out_data=0, out_sel_err=0. Data registers are reset to 0.
  - in_ready=1 during and after reset: all stages are empty, so adv[0]=1. A beat presented while rst=1 is discarded.
  - Reset mid-stream discards all in-flight beats. No partial beat appears afterwards.
- Simultaneous events:
  - Acceptance into stage 0 and a pop from stage L-1 can occur in the same cycle.
  - With all stages full and out_ready=1, the whole pipe shifts. Occupancy stays L.
- Degenerate case: when N <= R, L=1 and the block is a single registered mux with the same handshake.
- in_data and in_sel are sampled only on acceptance. Values presented without in_valid have no effect.

Test Plan:
- Directed walk (M=8, N=16, R=4, L=2): in_data[k]=8'h10+k; send sel=0..15 back-to-back with out_ready=1 -> out_data = 8'h10..8'h1F in order, first out_valid exactly 2 cycles after the first accept, 1 beat/cycle thereafter, out_sel_err=0.
- Non-power-of-radix (N=10, R=4, L=2): sel=9 -> in[9]; sel=12 -> out_data=0, out_sel_err=1; sel=15 -> out_data=0, out_sel_err=1.
- Back-pressure: stream 6 beats (sel=3,7,11,15,0,5), hold out_ready=0 for 4 cycles from cycle 3 -> in_ready drops once both stages are full, out_data holds 8'h13 stable, all 6 beats eventually emerge in order without loss.
- Bubble collapse: in_valid pattern 1,0,1,0 with out_ready=0 -> both beats pack into stages 1 and 0 and in_ready=0 afterwards; release out_ready -> beats exit on consecutive cycles.
- Reset mid-stream: 2 beats in flight, assert rst for 1 cycle -> next cycle out_valid=0, out_data=0, in_ready=1; the previous beats never appear; a new beat sel=2 emerges after 2 cycles as 8'h12.
- Radix 2 (R=2, N=8, L=3): random sel and in_data over 1000 beats with random out_ready -> scoreboard match against in[sel], latency >= 3.
